// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes, FSM states, defaults.
// Latency: n/a (constants and pure helper function only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Signed ops run on magnitudes and fix the signs up in S_FIX.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration over {acc, q}: shift-add multiply step or restoring-divide step.
// Latency: combinational.
// Backpressure: none; the controller decides when to register the result.
// Ports: is_div selects divide; acc_in/q_in/b_in current state and operand; acc_out/q_out next state.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] sub_lo;
    logic             borrow;

    // Multiply: add multiplicand when the multiplier LSB is set, then shift the
    // (WIDTH+1)-bit sum and the multiplier right together.
    assign sum = {1'b0, acc_in} + {1'b0, (q_in[0] ? b_in : {WIDTH{1'b0}})};

    // Divide: shift next dividend bit into the partial remainder, trial-subtract.
    // When the subtraction succeeds the difference is below b_in, so the low
    // WIDTH bits of the subtraction are exact.
    assign rem_sh = {acc_in, q_in[WIDTH-1]};
    assign borrow = rem_sh < {1'b0, b_in};
    assign sub_lo = rem_sh[WIDTH-1:0] - b_in;

    always_comb begin
        acc_out = acc_in;
        q_out   = q_in;
        if (is_div) begin
            acc_out = borrow ? rem_sh[WIDTH-1:0] : sub_lo;
            q_out   = {q_in[WIDTH-2:0], ~borrow};
        end else begin
            {acc_out, q_out} = {sum, q_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/DIV sequencer owning the HI/LO pair; MTHI/MTLO write directly.
// Latency: WIDTH+1 edges from accept to HI/LO commit, done pulses the cycle after; MT ops commit on accept.
// Backpressure: accept = start & ~busy; requester holds start until accepted.
// Ports: clk, reset (async active-high); start/op/A/B request; accept, busy, done, div_zero status;
//        hi/lo architectural registers. Optional HILO_MADD_EN enables accumulating ops 6/7.
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             accept,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, q, b_reg, a_raw;
    logic [WIDTH-1:0] acc_nxt, q_nxt;
    logic             is_div, neg_res, neg_rem, dz;
`ifdef HILO_MADD_EN
    logic             is_madd;
`endif

    logic             op_div, op_iter, sgn;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign busy   = (state != S_IDLE);
    assign accept = start & ~busy;

    always_comb begin
        op_div  = (op == OP_DIV) || (op == OP_DIVU);
        op_iter = op_div || (op == OP_MULT) || (op == OP_MULTU);
`ifdef HILO_MADD_EN
        op_iter = op_iter || (op == OP_MADD) || (op == OP_MADDU);
`endif
        sgn   = op_is_signed(op);
        a_abs = (sgn && A[WIDTH-1]) ? -A : A;
        b_abs = (sgn && B[WIDTH-1]) ? -B : B;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .q_in    (q),
        .b_in    (b_reg),
        .acc_out (acc_nxt),
        .q_out   (q_nxt)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && op_iter) state_nxt = S_RUN;
            S_RUN:  if (cnt == LAST)       state_nxt = S_FIX;
            S_FIX:                         state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    // Sign fix-up and commit values, consumed on the S_FIX exit edge.
    always_comb begin
        prod_s = neg_res ? -{acc, q} : {acc, q};
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
        if (is_div) begin
            if (dz) begin
                // Divide by zero: quotient saturates to all ones, HI keeps the raw dividend.
                res_hi = a_raw;
                res_lo = {WIDTH{1'b1}};
            end else begin
                res_hi = neg_rem ? -acc : acc;
                res_lo = neg_res ? -q : q;
            end
        end
`ifdef HILO_MADD_EN
        else if (is_madd) begin
            {res_hi, res_lo} = prod_s + {hi, lo};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            q        <= '0;
            b_reg    <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
`ifdef HILO_MADD_EN
            is_madd  <= 1'b0;
`endif
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_zero <= 1'b0;
                        if (op == OP_MTHI) hi <= A;
                        if (op == OP_MTLO) lo <= A;
                        if (op_iter) begin
                            cnt     <= '0;
                            acc     <= '0;
                            a_raw   <= A;
                            is_div  <= op_div;
                            neg_res <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_rem <= sgn & A[WIDTH-1];
                            dz      <= (B == '0);
`ifdef HILO_MADD_EN
                            is_madd <= (op == OP_MADD) || (op == OP_MADDU);
`endif
                            // Divide shifts the dividend out of q; multiply shifts the multiplier.
                            if (op_div) begin
                                q     <= a_abs;
                                b_reg <= b_abs;
                            end else begin
                                q     <= b_abs;
                                b_reg <= a_abs;
                            end
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                S_FIX: begin
                    hi       <= res_hi;
                    lo       <= res_lo;
                    done     <= 1'b1;
                    div_zero <= is_div & dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: hand-computed HI/LO results, latency, flags, stall and reset.
// Latency: n/a.
// Backpressure: the bench holds start until accept, as the pipeline does.
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        accept, busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .accept   (accept),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request once idle and hold it through the accept edge.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        #1;
        tick();
        start = 1'b0;
    endtask

    // Edges after the accept edge until done is seen; 100 means it never came.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic iter_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dz);
        int n;
        do_op(o, a, b);
        wait_done(n);
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " hi"}, {32'h0, hi}, {32'h0, exp_hi});
        check({tag, " lo"}, {32'h0, lo}, {32'h0, exp_lo});
        check({tag, " div_zero"}, {63'h0, div_zero}, {63'h0, exp_dz});
        tick();
        check({tag, " done pulse"}, {63'h0, done}, 64'd0);
    endtask

    initial begin
        int n;
        int done_cnt;
        logic [31:0] lo_prev;

        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset hi", {32'h0, hi}, 64'd0);
        check("reset lo", {32'h0, lo}, 64'd0);
        check("reset busy", {63'h0, busy}, 64'd0);
        check("reset done", {63'h0, done}, 64'd0);
        check("reset div_zero", {63'h0, div_zero}, 64'd0);

        // Multiply and divide results
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("busy after accept", {63'h0, busy}, 64'd1);
        wait_done(n);
        check("multu latency", 64'(n), 64'd33);
        check("multu hi", {32'h0, hi}, 64'hFFFF_FFFE);
        check("multu lo", {32'h0, lo}, 64'h0000_0001);
        tick();
        check("multu done pulse", {63'h0, done}, 64'd0);

        iter_op("mult -7*3", 3'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        iter_op("multu shift", 3'd1, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 1'b0);
        iter_op("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        iter_op("div 7/-2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        iter_op("divu 100/7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        iter_op("div min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        iter_op("divu by 0", 3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
        check("div_zero sticky", {63'h0, div_zero}, 64'd1);

        // MTLO clears div_zero and writes lo on the accept edge
        do_op(3'd5, 32'h1234, 32'h0);
        check("mtlo lo", {32'h0, lo}, 64'h1234);
        check("mtlo div_zero clr", {63'h0, div_zero}, 64'd0);
        check("mtlo busy", {63'h0, busy}, 64'd0);
        check("mtlo done", {63'h0, done}, 64'd0);
        do_op(3'd4, 32'hABCD, 32'h0);
        check("mthi hi", {32'h0, hi}, 64'hABCD);

        // Request while busy is held off, then starts back-to-back with done
        lo_prev = lo;
        do_op(3'd1, 32'd3, 32'd4);
        tick();
        tick();
        start = 1'b1;
        op    = 3'd0;
        A     = 32'd5;
        B     = 32'd6;
        #1;
        check("accept while busy", {63'h0, accept}, 64'd0);
        check("lo held mid-op", {32'h0, lo}, {32'h0, lo_prev});
        wait_done(n);
        check("b2b first lo", {32'h0, lo}, 64'd12);
        check("b2b accept with done", {63'h0, accept}, 64'd1);
        tick();
        start = 1'b0;
        check("b2b busy", {63'h0, busy}, 64'd1);
        wait_done(n);
        check("b2b latency", 64'(n), 64'd33);
        check("b2b second lo", {32'h0, lo}, 64'd30);
        check("b2b second hi", {32'h0, hi}, 64'd0);

        // Optional accumulate ops
`ifdef HILO_MADD_EN
        do_op(3'd4, 32'd0, 32'd0);
        do_op(3'd5, 32'd5, 32'd0);
        iter_op("maddu 2*3+5", 3'd7, 32'd2, 32'd3, 32'd0, 32'd11, 1'b0);
        iter_op("madd -1*1+11", 3'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd10, 1'b0);
`else
        do_op(3'd6, 32'd2, 32'd3);
        check("illegal busy", {63'h0, busy}, 64'd0);
        check("illegal hi", {32'h0, hi}, 64'd0);
        check("illegal lo", {32'h0, lo}, 64'd30);
        tick();
        check("illegal done", {63'h0, done}, 64'd0);
`endif

        // Reset in the middle of an iteration aborts without commit
        do_op(3'd1, 32'd9, 32'd9);
        for (int i = 0; i < 10; i++) tick();
        check("pre-reset busy", {63'h0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("mid reset busy", {63'h0, busy}, 64'd0);
        check("mid reset hi", {32'h0, hi}, 64'd0);
        check("mid reset lo", {32'h0, lo}, 64'd0);
        tick();
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("no done after reset", 64'(done_cnt), 64'd0);
        check("lo after reset", {32'h0, lo}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
